// File: rtl/seq_det_pkg.sv
// Shared constants and parameter checks for the serial dual-pattern detector.
package seq_det_pkg;

    localparam int         DEF_PAT_W  = 3;
    localparam logic [2:0] DEF_PAT_A  = 3'b101;
    localparam logic [2:0] DEF_PAT_B  = 3'b100;
    localparam int         DEF_THRESH = 2;
    localparam int         DEF_CNT_W  = 4;

    // THRESH must be reachable by a CNT_W-bit counter and never be zero.
    function automatic bit thresh_ok(input int thresh, input int cnt_w);
        longint max_cnt;
        max_cnt = (longint'(1) << cnt_w) - 1;
        return (thresh >= 1) && (longint'(thresh) <= max_cnt);
    endfunction

endpackage

// File: rtl/seq_window.sv
// Sliding sample window: history shift register plus a fill counter that
// marks when the window holds PAT_W samples taken since the last restart.
module seq_window
    import seq_det_pkg::*;
#(
    parameter int PAT_W = DEF_PAT_W
) (
    input  logic             clk,
    input  logic             i_srst,
    input  logic             i_x,
    input  logic             i_accept,
    input  logic             i_restart,
    output logic [PAT_W-1:0] o_window,
    output logic             o_legal
);

    localparam int                FILL_W   = $clog2(PAT_W);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W - 1);

    logic [PAT_W-2:0]  r_hist;
    logic [FILL_W-1:0] r_fill;

    assign o_window = {r_hist, i_x};
    assign o_legal  = (r_fill == FILL_MAX);

    // History keeps shifting on a restart; only the fill count drops back.
    always_ff @(posedge clk) begin
        if (i_srst) begin
            r_hist <= '0;
            r_fill <= '0;
        end else if (i_accept) begin
            r_hist <= o_window[PAT_W-2:0];
            if (i_restart) begin
                r_fill <= '0;
            end else if (!o_legal) begin
                r_fill <= r_fill + 1'b1;
            end
        end
    end

endmodule

// File: rtl/seq_pattern_counter.sv
// Dual-pattern serial detector: matches PAT_A/PAT_B on a sliding window,
// counts occurrences per pattern and pulses z when a count reaches THRESH.
module seq_pattern_counter
    import seq_det_pkg::*;
#(
    parameter int               PAT_W   = DEF_PAT_W,
    parameter logic [PAT_W-1:0] PAT_A   = DEF_PAT_A,
    parameter logic [PAT_W-1:0] PAT_B   = DEF_PAT_B,
    parameter int               THRESH  = DEF_THRESH,
    parameter int               CNT_W   = DEF_CNT_W,
    parameter bit               OVERLAP = 1'b1,
    parameter bit               CONSEC  = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             x,
    input  logic             x_valid,
    input  logic             clear,
    output logic             hit_a,
    output logic             hit_b,
    output logic             z,
    output logic [CNT_W-1:0] cnt_a,
    output logic [CNT_W-1:0] cnt_b
);

    generate
        if (PAT_W < 2 || !thresh_ok(THRESH, CNT_W)) begin : g_bad_params
            $error("seq_pattern_counter: illegal PAT_W/THRESH/CNT_W combination");
        end
    endgenerate

    logic             w_srst;
    logic             w_accept;
    logic             w_restart;
    logic [PAT_W-1:0] w_window;
    logic             w_legal;
    logic [1:0]       w_match;
    logic [1:0]       w_fire;

    logic [1:0]       r_hit;
    logic             r_z;

    assign w_srst    = rst | clear;
    assign w_accept  = x_valid & ~w_srst;
    assign w_restart = !OVERLAP && (|w_match);

    seq_window #(
        .PAT_W(PAT_W)
    ) u_window (
        .clk      (clk),
        .i_srst   (w_srst),
        .i_x      (x),
        .i_accept (w_accept),
        .i_restart(w_restart),
        .o_window (w_window),
        .o_legal  (w_legal)
    );

    // Channel 0 tracks pattern A, channel 1 pattern B.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_ch
            localparam logic [PAT_W-1:0] PAT = (gi == 0) ? PAT_A : PAT_B;

            logic [CNT_W-1:0] r_cnt;
            logic [CNT_W-1:0] w_inc;

            assign w_match[gi] = w_accept & w_legal & (w_window == PAT);
            assign w_inc       = r_cnt + 1'b1;
            assign w_fire[gi]  = w_match[gi] && (w_inc == CNT_W'(THRESH));

            // A count that reaches THRESH wraps to zero, so it never overflows.
            always_ff @(posedge clk) begin
                if (w_srst) begin
                    r_cnt <= '0;
                end else if (w_match[gi]) begin
                    r_cnt <= w_fire[gi] ? '0 : w_inc;
                end else if (CONSEC && w_match[1-gi]) begin
                    r_cnt <= '0;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (w_srst) begin
            r_hit <= '0;
            r_z   <= 1'b0;
        end else begin
            r_hit <= w_match;
            r_z   <= |w_fire;
        end
    end

    assign hit_a = r_hit[0];
    assign hit_b = r_hit[1];
    assign z     = r_z;
    assign cnt_a = g_ch[0].r_cnt;
    assign cnt_b = g_ch[1].r_cnt;

endmodule

// File: tb/tb_seq_pattern_counter.sv
// Bench for seq_pattern_counter: four configurations share one stimulus
// stream; table rows pin hand-derived results, the rest use a scoreboard model.
module tb_seq_pattern_counter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1, clear = 1'b0, x_valid = 1'b0, x = 1'b0;
    logic       ha[4], hb[4], zz[4];
    logic [3:0] ca[4], cb[4];

    // cfg0 default, cfg1 CONSEC=0, cfg2 OVERLAP=0, cfg3 PAT_A=000
    seq_pattern_counter u_def (
        .clk(clk), .rst(rst), .x(x), .x_valid(x_valid), .clear(clear),
        .hit_a(ha[0]), .hit_b(hb[0]), .z(zz[0]), .cnt_a(ca[0]), .cnt_b(cb[0]));
    seq_pattern_counter #(.CONSEC(1'b0)) u_indep (
        .clk(clk), .rst(rst), .x(x), .x_valid(x_valid), .clear(clear),
        .hit_a(ha[1]), .hit_b(hb[1]), .z(zz[1]), .cnt_a(ca[1]), .cnt_b(cb[1]));
    seq_pattern_counter #(.OVERLAP(1'b0)) u_noov (
        .clk(clk), .rst(rst), .x(x), .x_valid(x_valid), .clear(clear),
        .hit_a(ha[2]), .hit_b(hb[2]), .z(zz[2]), .cnt_a(ca[2]), .cnt_b(cb[2]));
    seq_pattern_counter #(.PAT_A(3'b000)) u_zero (
        .clk(clk), .rst(rst), .x(x), .x_valid(x_valid), .clear(clear),
        .hit_a(ha[3]), .hit_b(hb[3]), .z(zz[3]), .cnt_a(ca[3]), .cnt_b(cb[3]));

    typedef struct {
        int         cfg;
        string      tag;
        logic       r, cl, v, x;
        logic       ha, hb, z;
        logic [3:0] ca, cb;
    } vec_t;

    typedef struct {
        int         cfg;
        string      tag;
        logic       ha, hb, z;
        logic [3:0] ca, cb;
    } exp_t;

    vec_t tab[$];
    exp_t sbq[$];
    int   n_vec = 0;
    int   n_bad = 0;

    // Reference model state per configuration
    logic [2:0] m_pa[4];
    bit         m_ov[4], m_con[4];
    int         m_n[4], m_ca[4], m_cb[4];
    logic [1:0] m_last[4];

    task automatic add(input int c, input string t, input logic r, cl, v, xx,
                       input logic eha, ehb, ez, input logic [3:0] eca, ecb);
        vec_t e;
        e.cfg = c; e.tag = t; e.r = r; e.cl = cl; e.v = v; e.x = xx;
        e.ha = eha; e.hb = ehb; e.z = ez; e.ca = eca; e.cb = ecb;
        tab.push_back(e);
    endtask

    task automatic model_step(input int c, input logic r, cl, v, xx, output exp_t e);
        logic [2:0] win;
        bit ok, ma, mb, fa, fb;
        ma = 0; mb = 0; fa = 0; fb = 0;
        if (r || cl) begin
            m_n[c] = 0; m_last[c] = 2'b00; m_ca[c] = 0; m_cb[c] = 0;
        end else if (v) begin
            win = {m_last[c], xx};
            ok  = (m_n[c] >= 2);
            ma  = ok && (win == m_pa[c]);
            mb  = ok && (win == 3'b100);
            if (ma) begin
                if (m_ca[c] + 1 == 2) begin m_ca[c] = 0; fa = 1; end
                else m_ca[c] = m_ca[c] + 1;
            end else if (m_con[c] && mb) m_ca[c] = 0;
            if (mb) begin
                if (m_cb[c] + 1 == 2) begin m_cb[c] = 0; fb = 1; end
                else m_cb[c] = m_cb[c] + 1;
            end else if (m_con[c] && ma) m_cb[c] = 0;
            m_last[c] = {m_last[c][0], xx};
            if (!m_ov[c] && (ma || mb)) m_n[c] = 0;
            else if (m_n[c] < 2) m_n[c] = m_n[c] + 1;
        end
        e.cfg = c; e.tag = "";
        e.ha = ma; e.hb = mb; e.z = fa | fb;
        e.ca = 4'(m_ca[c]); e.cb = 4'(m_cb[c]);
    endtask

    task automatic check(input exp_t e);
        int c;
        c = e.cfg;
        n_vec++;
        if ({ha[c], hb[c], zz[c], ca[c], cb[c]} !== {e.ha, e.hb, e.z, e.ca, e.cb}) begin
            n_bad++;
            $display("FAIL %s cfg%0d: got ha=%b hb=%b z=%b ca=%0d cb=%0d, want ha=%b hb=%b z=%b ca=%0d cb=%0d",
                     e.tag, c, ha[c], hb[c], zz[c], ca[c], cb[c], e.ha, e.hb, e.z, e.ca, e.cb);
        end
    endtask

    // One clock: drive at negedge, queue expectations, compare after the edge.
    task automatic apply(input logic r, cl, v, xx, input int ocfg, input string tag,
                         input logic eha, ehb, ez, input logic [3:0] eca, ecb);
        exp_t e;
        @(negedge clk);
        rst = r; clear = cl; x_valid = v; x = xx;
        for (int c = 0; c < 4; c++) begin
            model_step(c, r, cl, v, xx, e);
            e.tag = tag;
            if (c == ocfg) begin
                e.ha = eha; e.hb = ehb; e.z = ez; e.ca = eca; e.cb = ecb;
            end
            sbq.push_back(e);
        end
        @(posedge clk);
        #1;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            check(e);
        end
        $display("%s r=%b c=%b v=%b x=%b -> cfg0 ha=%b hb=%b z=%b ca=%0d cb=%0d",
                 tag, r, cl, v, xx, ha[0], hb[0], zz[0], ca[0], cb[0]);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, want $finish before 2 ms");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int c = 0; c < 4; c++) begin
            m_pa[c] = (c == 3) ? 3'b000 : 3'b101;
            m_ov[c] = (c != 2);
            m_con[c] = (c != 1);
            m_n[c] = 0; m_ca[c] = 0; m_cb[c] = 0; m_last[c] = 2'b00;
        end

        //   cfg tag       r  cl v  x    ha hb z  ca cb
        add(0, "rst",      1, 0, 0, 0,   0, 0, 0, 0, 0);
        add(0, "t1s1",     0, 0, 1, 1,   0, 0, 0, 0, 0);
        add(0, "t1s2",     0, 0, 1, 0,   0, 0, 0, 0, 0);
        add(0, "t1s3",     0, 0, 1, 1,   1, 0, 0, 1, 0);
        add(0, "t1s4",     0, 0, 1, 0,   0, 0, 0, 1, 0);
        add(0, "t1s5",     0, 0, 1, 1,   1, 0, 1, 0, 0);
        add(0, "t1gap",    0, 0, 0, 1,   0, 0, 0, 0, 0);
        add(0, "rst",      1, 0, 0, 0,   0, 0, 0, 0, 0);
        add(0, "t2s1",     0, 0, 1, 1,   0, 0, 0, 0, 0);
        add(0, "t2s2",     0, 0, 1, 0,   0, 0, 0, 0, 0);
        add(0, "t2s3",     0, 0, 1, 1,   1, 0, 0, 1, 0);
        add(0, "t2s4",     0, 0, 1, 0,   0, 0, 0, 1, 0);
        add(0, "t2s5",     0, 0, 1, 0,   0, 1, 0, 0, 1);
        add(0, "rst",      1, 0, 0, 0,   0, 0, 0, 0, 0);
        add(0, "t4s1",     0, 0, 1, 1,   0, 0, 0, 0, 0);
        add(0, "t4gap1",   0, 0, 0, 0,   0, 0, 0, 0, 0);
        add(0, "t4s2",     0, 0, 1, 0,   0, 0, 0, 0, 0);
        add(0, "t4gap2",   0, 0, 0, 1,   0, 0, 0, 0, 0);
        add(0, "t4gap3",   0, 0, 0, 0,   0, 0, 0, 0, 0);
        add(0, "t4s3",     0, 0, 1, 1,   1, 0, 0, 1, 0);
        add(0, "t4gap4",   0, 0, 0, 1,   0, 0, 0, 1, 0);
        add(0, "rst",      1, 0, 0, 0,   0, 0, 0, 0, 0);
        add(0, "t5s1",     0, 0, 1, 1,   0, 0, 0, 0, 0);
        add(0, "t5s2",     0, 0, 1, 0,   0, 0, 0, 0, 0);
        add(0, "t5s3",     0, 0, 1, 1,   1, 0, 0, 1, 0);
        add(0, "t5rstv",   1, 0, 1, 1,   0, 0, 0, 0, 0);
        add(0, "t5p1",     0, 0, 1, 0,   0, 0, 0, 0, 0);
        add(0, "t5p2",     0, 0, 1, 1,   0, 0, 0, 0, 0);
        add(0, "t5q1",     0, 0, 1, 1,   0, 0, 0, 0, 0);
        add(0, "t5q2",     0, 0, 1, 0,   0, 0, 0, 0, 0);
        add(0, "t5q3",     0, 0, 1, 1,   1, 0, 0, 1, 0);
        add(0, "clrv",     0, 1, 1, 1,   0, 0, 0, 0, 0);
        add(0, "clr_s1",   0, 0, 1, 0,   0, 0, 0, 0, 0);
        add(0, "clr_s2",   0, 0, 1, 1,   0, 0, 0, 0, 0);
        add(0, "clr_s3",   0, 0, 1, 0,   0, 0, 0, 0, 0);
        add(1, "rst",      1, 0, 0, 0,   0, 0, 0, 0, 0);
        add(1, "t2bs1",    0, 0, 1, 1,   0, 0, 0, 0, 0);
        add(1, "t2bs2",    0, 0, 1, 0,   0, 0, 0, 0, 0);
        add(1, "t2bs3",    0, 0, 1, 1,   1, 0, 0, 1, 0);
        add(1, "t2bs4",    0, 0, 1, 0,   0, 0, 0, 1, 0);
        add(1, "t2bs5",    0, 0, 1, 0,   0, 1, 0, 1, 1);
        add(2, "rst",      1, 0, 0, 0,   0, 0, 0, 0, 0);
        add(2, "t3s1",     0, 0, 1, 1,   0, 0, 0, 0, 0);
        add(2, "t3s2",     0, 0, 1, 0,   0, 0, 0, 0, 0);
        add(2, "t3s3",     0, 0, 1, 1,   1, 0, 0, 1, 0);
        add(2, "t3s4",     0, 0, 1, 0,   0, 0, 0, 1, 0);
        add(2, "t3s5",     0, 0, 1, 1,   0, 0, 0, 1, 0);
        add(2, "t3s6",     0, 0, 1, 1,   0, 0, 0, 1, 0);
        add(2, "t3s7",     0, 0, 1, 0,   0, 0, 0, 1, 0);
        add(2, "t3s8",     0, 0, 1, 1,   1, 0, 1, 0, 0);
        add(3, "rst",      1, 0, 0, 0,   0, 0, 0, 0, 0);
        add(3, "t6clrv",   0, 1, 1, 0,   0, 0, 0, 0, 0);
        add(3, "t6s1",     0, 0, 1, 0,   0, 0, 0, 0, 0);
        add(3, "t6s2",     0, 0, 1, 0,   0, 0, 0, 0, 0);
        add(3, "t6s3",     0, 0, 1, 0,   1, 0, 0, 1, 0);
        add(3, "t6s4",     0, 0, 1, 0,   1, 0, 1, 0, 0);

        foreach (tab[i])
            apply(tab[i].r, tab[i].cl, tab[i].v, tab[i].x, tab[i].cfg, tab[i].tag,
                  tab[i].ha, tab[i].hb, tab[i].z, tab[i].ca, tab[i].cb);

        // Random stream, all configurations checked against the model
        for (int i = 0; i < 300; i++) begin
            logic r, cl, v, xx;
            r  = ($urandom_range(0, 49) == 0);
            cl = ($urandom_range(0, 39) == 0);
            v  = ($urandom_range(0, 3) != 0);
            xx = 1'($urandom_range(0, 1));
            apply(r, cl, v, xx, -1, "rnd", 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
